// File: rtl/sound_decoder.sv
// Square-wave audio receiver: measures the audio half-period in hsync lines, locks onto a tone code
// and reports start/change/end events plus the tone's duration in frames.
module sound_decoder #(
  parameter int TOL     = 3,
  parameter int SILENCE = 320,
  parameter int DUR_W   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             audio_in,
  output logic             tone_valid,
  output logic [3:0]       tone_code,
  output logic             tone_start,
  output logic             tone_change,
  output logic             tone_end,
  output logic [DUR_W-1:0] tone_frames
);

  typedef enum logic [1:0] {IDLE, ARM, CONF, TONE} state_t;

  state_t     state, state_n;
  logic [2:0] audio_sync;
  logic       prev_hsync, prev_vsync;
  logic [8:0] line_cnt;
  logic [3:0] cand, cand_n, code_n;
  logic       valid_n, start_n, change_n, end_n;

  logic       toggle, hs_edge, vs_edge, silent;
  logic [5:0] code_p1;
  logic [3:0] code;
  logic [9:0] h_ext, ref_h;
  logic       ok;

  // Two flops resynchronise audio_in; the third gives the previous level for edge detection.
  assign toggle  = audio_sync[1] ^ audio_sync[2];
  assign hs_edge = hsync & ~prev_hsync;
  assign vs_edge = vsync & ~prev_vsync;
  assign silent  = line_cnt >= 9'(SILENCE);

  // Nearest code by rounding, then accept only within TOL lines of its exact half-period.
  assign h_ext   = 10'(line_cnt);
  assign code_p1 = 6'((h_ext + 10'd8) >> 4);
  assign code    = 4'(code_p1 - 6'd1);
  assign ref_h   = {code_p1, 4'b0000};
  assign ok      = (line_cnt >= 9'd8) && (line_cnt <= 9'd263) &&
                   (h_ext + 10'(TOL) >= ref_h) && (h_ext <= ref_h + 10'(TOL));

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      audio_sync <= '0;
      prev_hsync <= 1'b0;
      prev_vsync <= 1'b0;
      line_cnt   <= '0;
    end else begin
      audio_sync <= {audio_sync[1:0], audio_in};
      prev_hsync <= hsync;
      prev_vsync <= vsync;
      if (toggle)
        line_cnt <= '0;
      else if (hs_edge && line_cnt != 9'd511)
        line_cnt <= line_cnt + 9'd1;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    state_n  = state;
    cand_n   = cand;
    code_n   = tone_code;
    valid_n  = tone_valid;
    start_n  = 1'b0;
    change_n = 1'b0;
    end_n    = 1'b0;
    if (toggle) begin
      unique case (state)
        IDLE: state_n = ARM;
        ARM: begin
          if (ok) begin
            cand_n  = code;
            state_n = CONF;
          end
        end
        CONF: begin
          if (ok && code == cand) begin
            state_n = TONE;
            valid_n = 1'b1;
            code_n  = cand;
            start_n = 1'b1;
          end else if (ok) begin
            cand_n = code;
          end else begin
            state_n = ARM;
          end
        end
        TONE: begin
          if (ok && code != tone_code) begin
            code_n   = code;
            change_n = 1'b1;
          end else if (!ok) begin
            end_n   = 1'b1;
            valid_n = 1'b0;
            state_n = ARM;
          end
        end
        default: state_n = IDLE;
      endcase
    end else if (state != IDLE && silent) begin
      state_n = IDLE;
      if (state == TONE) begin
        end_n   = 1'b1;
        valid_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cand        <= '0;
      tone_valid  <= 1'b0;
      tone_code   <= '0;
      tone_start  <= 1'b0;
      tone_change <= 1'b0;
      tone_end    <= 1'b0;
      tone_frames <= '0;
    end else begin
      state       <= state_n;
      cand        <= cand_n;
      tone_valid  <= valid_n;
      tone_code   <= code_n;
      tone_start  <= start_n;
      tone_change <= change_n;
      tone_end    <= end_n;
      if (start_n)
        tone_frames <= '0;
      else if (state == TONE && vs_edge && tone_frames != '1)
        tone_frames <= tone_frames + 1'b1;
    end
  end

endmodule

// File: tb/tb_sound_decoder.sv
// Bench for sound_decoder: line-accurate audio stimulus against a pair-lock reference model.
module tb_sound_decoder;
  localparam int TOL     = 3;
  localparam int SILENCE = 320;
  localparam int DUR_W   = 6;
  localparam int LINE    = 8;
  localparam int FMAX    = (1 << DUR_W) - 1;

  logic clk, rst, hsync, vsync, audio_in;
  logic tone_valid, tone_start, tone_change, tone_end;
  logic [3:0] tone_code;
  logic [DUR_W-1:0] tone_frames;

  sound_decoder #(.TOL(TOL), .SILENCE(SILENCE), .DUR_W(DUR_W)) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .audio_in(audio_in),
    .tone_valid(tone_valid), .tone_code(tone_code), .tone_start(tone_start),
    .tone_change(tone_change), .tone_end(tone_end), .tone_frames(tone_frames)
  );

  int n_checks = 0, n_fail = 0;
  int n_start = 0, n_change = 0, n_end = 0, n_multi = 0;
  int exp_start = 0, exp_change = 0, exp_end = 0, exp_frames = 0, exp_code = 0;
  bit exp_valid = 0, have_edge = 0, lost_edge = 0;
  int prev_code = -1;

  event mid_ev, pre_ev;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line generator: hsync high on phase 0; mid_ev marks a quiet point, pre_ev lands a toggle on the next hsync edge.
  initial begin
    hsync = 1'b0;
    forever
      for (int p = 0; p < LINE; p++) begin
        @(negedge clk);
        hsync = (p == 0);
        if (p == 3) ->mid_ev;
        if (p == 6) ->pre_ev;
      end
  end

  always @(negedge clk) begin
    if (tone_start)  n_start++;
    if (tone_change) n_change++;
    if (tone_end)    n_end++;
    if (int'(tone_start) + int'(tone_change) + int'(tone_end) > 1) n_multi++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: a tone locks on two consecutive acceptable measurements with equal codes
  // following a first edge; a rejected measurement breaks the pair or drops the tone.
  task automatic model_silence();
    if (have_edge && exp_valid) begin
      exp_end++;
      exp_valid = 0;
    end
    have_edge = 0;
    prev_code = -1;
  endtask

  task automatic model_reset();
    exp_valid = 0; exp_code = 0; exp_frames = 0;
    have_edge = 0; prev_code = -1; lost_edge = 0;
  endtask

  task automatic model_toggle(input int h);
    bit ok = 0;
    int c = 0;
    for (int k = 0; k < 16; k++)
      if (h >= 16 * (k + 1) - TOL && h <= 16 * (k + 1) + TOL) begin
        ok = 1;
        c  = k;
      end
    if (h >= SILENCE) model_silence();
    if (!have_edge) begin
      have_edge = 1;
      prev_code = -1;
    end else if (exp_valid) begin
      if (!ok) begin
        exp_end++;
        exp_valid = 0;
        prev_code = -1;
      end else if (c != exp_code) begin
        exp_code = c;
        exp_change++;
      end
    end else if (!ok) begin
      prev_code = -1;
    end else if (c == prev_code) begin
      exp_valid  = 1;
      exp_code   = c;
      exp_frames = 0;
      exp_start++;
    end else begin
      prev_code = c;
    end
  endtask

  // Toggle audio h lines after the previous toggle, then move on one line so outputs have settled.
  task automatic tog(input int h);
    repeat (h - 1) @(mid_ev);
    audio_in = ~audio_in;
    model_toggle(lost_edge ? h - 1 : h);
    lost_edge = 0;
    @(mid_ev);
  endtask

  // Same, but timed so the toggle is detected on the cycle of the following hsync edge.
  task automatic tog_pre(input int h);
    repeat (h - 1) @(mid_ev);
    @(pre_ev);
    audio_in = ~audio_in;
    model_toggle(h);
    lost_edge = 1;
    @(mid_ev);
  endtask

  task automatic go_idle();
    repeat (SILENCE + 10) @(mid_ev);
    model_silence();
  endtask

  task automatic vs_pulses(input int n);
    repeat (n) begin
      @(negedge clk);
      vsync = 1'b1;
      @(negedge clk);
      vsync = 1'b0;
      if (exp_valid && exp_frames < FMAX) exp_frames++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; audio_in = 1'b0; vsync = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({tone_valid, tone_code, tone_start, tone_change, tone_end, tone_frames} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: outputs=%0h expected 0",
               {tone_valid, tone_code, tone_start, tone_change, tone_end, tone_frames});
    end
    rst = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    n_checks++;
    if ({tone_valid, tone_code, tone_frames} !== '0 || n_start + n_change + n_end != 0) begin
      n_fail++;
      $display("FAIL reset_release: valid=%0b code=%0d frames=%0d pulses=%0d expected all 0",
               tone_valid, tone_code, tone_frames, n_start + n_change + n_end);
    end
  endtask

  task automatic test_lock();
    for (int i = 0; i < 10; i++) begin
      tog(64);
      n_checks++;
      if (tone_valid !== exp_valid || tone_code !== 4'(exp_code) || n_start != exp_start) begin
        n_fail++;
        $display("FAIL lock_64 toggle %0d: valid=%0b code=%0d starts=%0d expected %0b/%0d/%0d",
                 i, tone_valid, tone_code, n_start, exp_valid, exp_code, exp_start);
      end
    end
    n_checks++;
    if (tone_valid !== 1'b1 || tone_code !== 4'd3 || n_start != 1) begin
      n_fail++;
      $display("FAIL lock_code3: valid=%0b code=%0d starts=%0d expected 1/3/1",
               tone_valid, tone_code, n_start);
    end
  endtask

  task automatic test_change();
    for (int i = 0; i < 3; i++) begin
      tog(80);
      n_checks++;
      if (tone_valid !== exp_valid || tone_code !== 4'(exp_code) ||
          n_change != exp_change || n_end != exp_end) begin
        n_fail++;
        $display("FAIL change_80 toggle %0d: valid=%0b code=%0d chg=%0d end=%0d expected %0b/%0d/%0d/%0d",
                 i, tone_valid, tone_code, n_change, n_end, exp_valid, exp_code, exp_change, exp_end);
      end
    end
    n_checks++;
    if (tone_code !== 4'd4 || n_change != 1) begin
      n_fail++;
      $display("FAIL change_code4: code=%0d changes=%0d expected 4/1", tone_code, n_change);
    end
  endtask

  task automatic test_silence();
    vs_pulses(5);
    repeat (SILENCE - 4) @(mid_ev);
    n_checks++;
    if (tone_valid !== 1'b1 || n_end != exp_end || tone_frames !== DUR_W'(exp_frames)) begin
      n_fail++;
      $display("FAIL silence_before: valid=%0b ends=%0d frames=%0d expected 1/%0d/%0d",
               tone_valid, n_end, tone_frames, exp_end, exp_frames);
    end
    repeat (3) @(mid_ev);
    model_silence();
    n_checks++;
    if (tone_valid !== 1'b0 || n_end != exp_end || tone_frames !== DUR_W'(5)) begin
      n_fail++;
      $display("FAIL silence_end: valid=%0b ends=%0d frames=%0d expected 0/%0d/5",
               tone_valid, n_end, tone_frames, exp_end);
    end
  endtask

  task automatic test_tolerance();
    int hs[9] = '{64, 64, 64, 66, 62, 67, 70, 64, 64};
    for (int i = 0; i < 9; i++) begin
      tog(hs[i]);
      n_checks++;
      if (tone_valid !== exp_valid || tone_code !== 4'(exp_code) || n_end != exp_end ||
          n_change != exp_change) begin
        n_fail++;
        $display("FAIL tol h=%0d: valid=%0b code=%0d end=%0d chg=%0d expected %0b/%0d/%0d/%0d",
                 hs[i], tone_valid, tone_code, n_end, n_change, exp_valid, exp_code, exp_end, exp_change);
      end
    end
    n_checks++;
    if (tone_valid !== 1'b1 || tone_code !== 4'd3) begin
      n_fail++;
      $display("FAIL tol_relock_two: valid=%0b code=%0d expected 1/3", tone_valid, tone_code);
    end
  endtask

  task automatic test_coincident();
    int ends0;
    go_idle();
    repeat (3) tog(160);
    n_checks++;
    if (tone_valid !== 1'b1 || tone_code !== 4'd9) begin
      n_fail++;
      $display("FAIL coinc_lock160: valid=%0b code=%0d expected 1/9", tone_valid, tone_code);
    end
    ends0 = n_end;
    tog_pre(160);
    tog(164);
    n_checks++;
    if (tone_valid !== 1'b1 || tone_code !== 4'd9 || n_end != ends0 || n_end != exp_end) begin
      n_fail++;
      $display("FAIL coinc_lost_edge: valid=%0b code=%0d ends=%0d expected 1/9/%0d",
               tone_valid, tone_code, n_end, ends0);
    end
  endtask

  task automatic test_saturation();
    vs_pulses(FMAX + 7);
    @(negedge clk);
    n_checks++;
    if (tone_frames !== DUR_W'(exp_frames) || exp_frames != FMAX) begin
      n_fail++;
      $display("FAIL frames_sat: frames=%0d expected %0d", tone_frames, FMAX);
    end
  endtask

  task automatic test_rst_mid_tone();
    int pulses0;
    pulses0 = n_start + n_change + n_end;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({tone_valid, tone_code, tone_start, tone_change, tone_end, tone_frames} !== '0) begin
      n_fail++;
      $display("FAIL rst_async: outputs=%0h expected 0",
               {tone_valid, tone_code, tone_start, tone_change, tone_end, tone_frames});
    end
    audio_in = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(mid_ev);
    n_checks++;
    if (n_start + n_change + n_end != pulses0) begin
      n_fail++;
      $display("FAIL rst_no_pulse: pulses=%0d expected %0d", n_start + n_change + n_end, pulses0);
    end
    for (int i = 0; i < 3; i++) begin
      tog(96);
      n_checks++;
      if (tone_valid !== (i == 2) || tone_code !== 4'(exp_code) || tone_valid !== exp_valid) begin
        n_fail++;
        $display("FAIL rst_relock toggle %0d: valid=%0b code=%0d expected %0b/%0d",
                 i, tone_valid, tone_code, exp_valid, exp_code);
      end
    end
  endtask

  task automatic test_random();
    int c = 2, h;
    go_idle();
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 9) >= 7) c = $urandom_range(0, 7);
      h = 16 * (c + 1) + $urandom_range(0, 10) - 5;
      tog(h);
      n_checks++;
      if (tone_valid !== exp_valid || tone_code !== 4'(exp_code) || n_start != exp_start ||
          n_change != exp_change || n_end != exp_end) begin
        n_fail++;
        $display("FAIL rand %0d h=%0d: v=%0b c=%0d s/c/e=%0d/%0d/%0d expected %0b/%0d %0d/%0d/%0d",
                 i, h, tone_valid, tone_code, n_start, n_change, n_end,
                 exp_valid, exp_code, exp_start, exp_change, exp_end);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_change();
    test_silence();
    test_tolerance();
    test_coincident();
    test_saturation();
    test_rst_mid_tone();
    test_random();
    n_checks++;
    if (n_multi != 0) begin
      n_fail++;
      $display("FAIL pulse_exclusive: overlapping pulse cycles=%0d expected 0", n_multi);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
